// File: rtl/la_capture_engine.sv
// rtl/la_capture_engine.sv - logic analyzer trigger-and-capture engine with circular buffer and streamed readout
module la_capture_engine #(
    parameter int  CH_W  = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH_W-1:0] samp_in,
    input  logic [7:0]      cfg_div,
    input  logic [AW-1:0]   cfg_pre,
    input  logic [CH_W-1:0] trig_mask,
    input  logic [CH_W-1:0] trig_value,
    input  logic [CH_W-1:0] trig_edge,
    input  logic            arm,
    input  logic            abort,
    output logic [2:0]      state,
    output logic            triggered,
    output logic [CH_W-1:0] rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic            rd_last
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_TRIG = 3'd2,
        S_POST = 3'd3,
        S_READ = 3'd4
    } state_t;

    state_t          state_q;
    logic [7:0]      div_q;
    logic [7:0]      div_cnt_q;
    logic [AW-1:0]   pre_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   trig_idx_q;
    logic [AW-1:0]   post_q;
    logic [AW-1:0]   rd_cnt_q;
    logic [AW:0]     fill_q;
    logic [CH_W-1:0] mask_q;
    logic [CH_W-1:0] value_q;
    logic [CH_W-1:0] edge_q;
    logic [CH_W-1:0] prev_q;
    logic [CH_W-1:0] rd_data_q;
    logic            triggered_q;
    logic            rd_valid_q;
    logic            rd_last_q;
    logic [CH_W-1:0] mem_q [DEPTH];

    logic            sampling;
    logic            tick;
    logic            samp_we;
    logic            hit;
    logic            rd_load;
    logic            rd_done;
    logic [CH_W-1:0] bit_ok;
    logic [AW:0]     fill_d;
    logic [AW-1:0]   post_d;

    assign sampling = state_q inside {S_PRE, S_TRIG, S_POST};
    assign tick     = (div_cnt_q == div_q);
    assign samp_we  = !rst && !abort && sampling && tick;

    // Edge bits compare against the previous sample; level bits against trig_value.
    assign bit_ok   = (edge_q & ~prev_q & samp_in) | (~edge_q & ~(samp_in ^ value_q));
    assign hit      = &(~mask_q | bit_ok);

    assign fill_d   = (fill_q == (AW+1)'(DEPTH)) ? fill_q : fill_q + (AW+1)'(1);
    assign post_d   = AW'(DEPTH-1) - pre_q;

    // A pending last sample is never replaced; its transfer ends the readout.
    assign rd_done  = rd_valid_q && rd_ready && rd_last_q;
    assign rd_load  = (!rd_valid_q || rd_ready) && !rd_last_q;

    always_ff @(posedge clk) begin
        if (samp_we) begin
            mem_q[wr_ptr_q] <= samp_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            div_cnt_q   <= '0;
            pre_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_idx_q  <= '0;
            post_q      <= '0;
            rd_cnt_q    <= '0;
            fill_q      <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            edge_q      <= '0;
            prev_q      <= '0;
            rd_data_q   <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else if (abort && state_q != S_IDLE) begin
            state_q     <= S_IDLE;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            if (sampling) begin
                div_cnt_q <= tick ? 8'd0 : div_cnt_q + 8'd1;
                if (tick) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    prev_q   <= samp_in;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (arm && !abort) begin
                        div_q     <= cfg_div;
                        pre_q     <= cfg_pre;
                        mask_q    <= trig_mask;
                        value_q   <= trig_value;
                        edge_q    <= trig_edge;
                        div_cnt_q <= '0;
                        prev_q    <= '0;
                        wr_ptr_q  <= '0;
                        fill_q    <= '0;
                        state_q   <= (cfg_pre == '0) ? S_TRIG : S_PRE;
                    end
                end
                S_PRE: begin
                    if (tick) begin
                        fill_q <= fill_d;
                        if (fill_d == {1'b0, pre_q}) begin
                            state_q <= S_TRIG;
                        end
                    end
                end
                S_TRIG: begin
                    if (tick && hit) begin
                        trig_idx_q  <= wr_ptr_q;
                        triggered_q <= 1'b1;
                        post_q      <= post_d;
                        if (post_d == '0) begin
                            state_q  <= S_READ;
                            rd_ptr_q <= wr_ptr_q - pre_q;
                            rd_cnt_q <= '0;
                        end else begin
                            state_q <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (tick) begin
                        post_q <= post_q - AW'(1);
                        if (post_q == AW'(1)) begin
                            state_q  <= S_READ;
                            rd_ptr_q <= trig_idx_q - pre_q;
                            rd_cnt_q <= '0;
                        end
                    end
                end
                S_READ: begin
                    if (rd_done) begin
                        state_q     <= S_IDLE;
                        rd_valid_q  <= 1'b0;
                        rd_last_q   <= 1'b0;
                        triggered_q <= 1'b0;
                    end else if (rd_load) begin
                        rd_data_q  <= mem_q[rd_ptr_q];
                        rd_valid_q <= 1'b1;
                        rd_last_q  <= (rd_cnt_q == AW'(DEPTH-1));
                        rd_ptr_q   <= rd_ptr_q + AW'(1);
                        rd_cnt_q   <= rd_cnt_q + AW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state     = state_q;
    assign triggered = triggered_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
endmodule

// File: tb/tb_la_capture_engine.sv
// tb/tb_la_capture_engine.sv - self-checking bench for la_capture_engine against a sample-index reference model
module tb_la_capture_engine;
    localparam int CH_W  = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SLEN  = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH_W-1:0] samp_in;
    logic [7:0]      cfg_div;
    logic [AW-1:0]   cfg_pre;
    logic [CH_W-1:0] trig_mask, trig_value, trig_edge;
    logic            arm, abort;
    logic [2:0]      state;
    logic            triggered;
    logic [CH_W-1:0] rd_data;
    logic            rd_valid, rd_ready, rd_last;

    la_capture_engine #(.CH_W(CH_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .samp_in(samp_in), .cfg_div(cfg_div), .cfg_pre(cfg_pre),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .arm(arm), .abort(abort), .state(state), .triggered(triggered),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] stim [SLEN];

    logic [7:0] got [DEPTH];
    logic       got_last [DEPTH];
    logic [7:0] exp_win [DEPTH];
    int n_got, trig_state, rd_lag, end_state, stall_bad, held_cycles;
    logic end_valid, end_trig;
    logic [7:0] held_val;

    // Stimulus index = clocks since the arm edge; samp_in holds stim[cyc] up to edge cyc.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        samp_in = (cyc < SLEN) ? stim[cyc] : 8'h00;
    endtask

    // Sample k after arm is captured on edge (div+1)*(k+1).
    function automatic logic [7:0] sample_at(int div, int k);
        int idx;
        idx = (div + 1) * (k + 1);
        return (idx < SLEN) ? stim[idx] : 8'h00;
    endfunction

    function automatic int find_trigger(int div, int pre, logic [7:0] m, logic [7:0] v, logic [7:0] e);
        logic [7:0] s, p;
        bit hit;
        for (int k = pre; k < 150; k++) begin
            s = sample_at(div, k);
            p = (k == 0) ? 8'h00 : sample_at(div, k - 1);
            hit = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (m[i]) begin
                    if (e[i]) begin
                        if (!(!p[i] && s[i])) hit = 1'b0;
                    end else if (s[i] != v[i]) begin
                        hit = 1'b0;
                    end
                end
            end
            if (hit) return k;
        end
        return -1;
    endfunction

    task automatic build_expected(int div, int pre, int k);
        for (int j = 0; j < DEPTH; j++) exp_win[j] = sample_at(div, k - pre + j);
    endtask

    task automatic run_capture(int div, int pre, logic [7:0] m, logic [7:0] v, logic [7:0] e,
                               int bp_at, bit rnd_ready);
        int read_t, valid_t, hold;
        bit prev_stall;
        logic [7:0] pd;
        logic pl;
        cfg_div = 8'(div); cfg_pre = 4'(pre);
        trig_mask = m; trig_value = v; trig_edge = e;
        cyc = 0; samp_in = stim[0]; arm = 1'b1;
        step();
        arm = 1'b0;
        cfg_div = 8'($urandom); cfg_pre = 4'($urandom);
        trig_mask = 8'($urandom); trig_value = 8'($urandom); trig_edge = 8'($urandom);
        n_got = 0; trig_state = -1; read_t = -1; valid_t = -1; hold = 0;
        stall_bad = 0; held_cycles = 0; held_val = 8'h00; prev_stall = 1'b0; pd = 8'h00; pl = 1'b0;
        for (int t = 0; t < 3000 && n_got < DEPTH; t++) begin
            if (trig_state < 0 && triggered) trig_state = int'(state);
            if (read_t < 0 && state == 3'd4) read_t = t;
            if (valid_t < 0 && rd_valid) valid_t = t;
            if (prev_stall && (rd_data !== pd || rd_last !== pl || rd_valid !== 1'b1)) stall_bad++;
            if (hold > 0) begin
                rd_ready = 1'b0;
                hold--;
            end else begin
                rd_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (rd_valid && !rd_ready) begin
                held_val = rd_data;
                held_cycles++;
            end
            prev_stall = rd_valid && !rd_ready;
            pd = rd_data;
            pl = rd_last;
            if (rd_valid && rd_ready) begin
                got[n_got] = rd_data;
                got_last[n_got] = rd_last;
                n_got++;
                if (n_got == bp_at) hold = 3;
            end
            step();
        end
        rd_lag = (read_t >= 0 && valid_t >= 0) ? valid_t - read_t : -1;
        end_state = int'(state);
        end_valid = rd_valid;
        end_trig = triggered;
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < SLEN; i++) stim[i] = 8'h00;
        cyc = 0; samp_in = 8'h00; rd_ready = 1'b0; abort = 1'b0;
        cfg_div = 8'h00; cfg_pre = 4'h0; trig_mask = 8'h00; trig_value = 8'h00; trig_edge = 8'h00;
        rst = 1'b1; arm = 1'b1;
        step();
        step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", state); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b expected 0", rd_valid); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered got %b expected 0", triggered); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h expected 00", rd_data); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got %b expected 0", rd_last); end
        rst = 1'b0; arm = 1'b0;
        step();
    endtask

    task automatic test_level_trigger();
        int k;
        for (int i = 0; i < SLEN; i++) stim[i] = 8'(8'hA0 + i);
        k = find_trigger(0, 4, 8'hFF, 8'hA5, 8'h00);
        build_expected(0, 4, k);
        run_capture(0, 4, 8'hFF, 8'hA5, 8'h00, -1, 1'b0);
        checks++; if (n_got != DEPTH) begin errors++; $display("FAIL level_count got %0d expected %0d", n_got, DEPTH); end
        for (int j = 0; j < DEPTH; j++) begin
            checks++;
            if (got[j] !== exp_win[j]) begin errors++; $display("FAIL level_data[%0d] got %h expected %h", j, got[j], exp_win[j]); end
            checks++;
            if (got_last[j] !== (j == DEPTH - 1)) begin errors++; $display("FAIL level_last[%0d] got %b expected %b", j, got_last[j], j == DEPTH - 1); end
        end
        checks++; if (got[0] !== 8'hA1) begin errors++; $display("FAIL level_first got %h expected a1", got[0]); end
        checks++; if (got[DEPTH-1] !== 8'hB0) begin errors++; $display("FAIL level_final got %h expected b0", got[DEPTH-1]); end
        checks++; if (trig_state != 3) begin errors++; $display("FAIL level_state_after_trig got %0d expected 3", trig_state); end
        checks++; if (rd_lag != 1) begin errors++; $display("FAIL level_rd_valid_lag got %0d expected 1", rd_lag); end
        checks++; if (end_state != 0 || end_valid !== 1'b0 || end_trig !== 1'b0) begin
            errors++; $display("FAIL level_end got state=%0d valid=%b trig=%b expected 0/0/0", end_state, end_valid, end_trig);
        end
    endtask

    task automatic test_edge_trigger();
        int k;
        for (int i = 0; i < SLEN; i++) stim[i] = 8'($urandom);
        stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h01; stim[4] = 8'h00; stim[5] = 8'h01;
        k = find_trigger(0, 0, 8'h01, 8'h00, 8'h01);
        build_expected(0, 0, k);
        run_capture(0, 0, 8'h01, 8'h00, 8'h01, -1, 1'b0);
        checks++; if (got[0] !== 8'h01) begin errors++; $display("FAIL edge_first got %h expected 01", got[0]); end
        for (int j = 0; j < DEPTH; j++) begin
            checks++;
            if (got[j] !== exp_win[j]) begin errors++; $display("FAIL edge_data[%0d] got %h expected %h", j, got[j], exp_win[j]); end
        end
        checks++; if (end_state != 0) begin errors++; $display("FAIL edge_end_state got %0d expected 0", end_state); end
    endtask

    task automatic test_backpressure();
        int k;
        for (int i = 0; i < SLEN; i++) stim[i] = 8'(8'hA0 + i);
        k = find_trigger(0, 4, 8'hFF, 8'hA5, 8'h00);
        build_expected(0, 4, k);
        run_capture(0, 4, 8'hFF, 8'hA5, 8'h00, 5, 1'b0);
        checks++; if (n_got != DEPTH) begin errors++; $display("FAIL bp_count got %0d expected %0d", n_got, DEPTH); end
        checks++; if (held_val !== 8'hA6) begin errors++; $display("FAIL bp_held_data got %h expected a6", held_val); end
        checks++; if (held_cycles != 3) begin errors++; $display("FAIL bp_held_cycles got %0d expected 3", held_cycles); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable got %0d expected 0", stall_bad); end
        for (int j = 0; j < DEPTH; j++) begin
            checks++;
            if (got[j] !== exp_win[j]) begin errors++; $display("FAIL bp_data[%0d] got %h expected %h", j, got[j], exp_win[j]); end
        end
    endtask

    task automatic test_abort_prescaler();
        int t, k, tries;
        logic [7:0] m, v;
        for (int i = 0; i < SLEN; i++) stim[i] = 8'($urandom);
        cfg_div = 8'd3; cfg_pre = 4'd2; trig_mask = 8'h00; trig_value = 8'h00; trig_edge = 8'h00;
        cyc = 0; samp_in = stim[0]; arm = 1'b1;
        step();
        arm = 1'b0;
        t = 0;
        while (state !== 3'd3 && t < 300) begin step(); t++; end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL abort_reach_post got %0d expected 3", state); end
        arm = 1'b1;
        step();
        arm = 1'b0;
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL arm_ignored_in_post got %0d expected 3", state); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL abort_state got %0d expected 0", state); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL abort_triggered got %b expected 0", triggered); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL abort_rd_valid got %b expected 0", rd_valid); end
        abort = 1'b1; arm = 1'b1;
        step();
        abort = 1'b0; arm = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL abort_beats_arm got %0d expected 0", state); end
        k = -1; tries = 0;
        m = 8'h01 << $urandom_range(7);
        v = 8'($urandom);
        while (k < 0 && tries < 50) begin
            for (int i = 0; i < SLEN; i++) stim[i] = 8'($urandom);
            k = find_trigger(3, 15, m, v, 8'h00);
            tries++;
        end
        build_expected(3, 15, k);
        run_capture(3, 15, m, v, 8'h00, -1, 1'b0);
        checks++; if (trig_state != 4) begin errors++; $display("FAIL pre15_state_after_trig got %0d expected 4", trig_state); end
        for (int j = 0; j < DEPTH; j++) begin
            checks++;
            if (got[j] !== exp_win[j]) begin errors++; $display("FAIL pre15_data[%0d] got %h expected %h", j, got[j], exp_win[j]); end
        end
        checks++; if (end_state != 0) begin errors++; $display("FAIL pre15_end_state got %0d expected 0", end_state); end
    endtask

    task automatic test_mask_zero();
        int k;
        for (int i = 0; i < SLEN; i++) stim[i] = 8'($urandom);
        k = find_trigger(0, 2, 8'h00, 8'h00, 8'h00);
        build_expected(0, 2, k);
        run_capture(0, 2, 8'h00, 8'($urandom), 8'($urandom), -1, 1'b0);
        for (int j = 0; j < DEPTH; j++) begin
            checks++;
            if (got[j] !== stim[j+1]) begin errors++; $display("FAIL mask0_data[%0d] got %h expected %h", j, got[j], stim[j+1]); end
        end
        checks++; if (got[DEPTH-1] !== exp_win[DEPTH-1]) begin errors++; $display("FAIL mask0_model_last got %h expected %h", got[DEPTH-1], exp_win[DEPTH-1]); end
    endtask

    task automatic test_random();
        int div, pre, k, tries;
        logic [7:0] m, v, e;
        for (int it = 0; it < 4; it++) begin
            div = $urandom_range(3);
            pre = $urandom_range(15);
            m = (8'h01 << $urandom_range(7)) | (8'h01 << $urandom_range(7));
            v = 8'($urandom);
            e = 8'($urandom) & m;
            k = -1; tries = 0;
            while (k < 0 && tries < 50) begin
                for (int i = 0; i < SLEN; i++) stim[i] = 8'($urandom);
                k = find_trigger(div, pre, m, v, e);
                tries++;
            end
            build_expected(div, pre, k);
            run_capture(div, pre, m, v, e, -1, 1'b1);
            checks++; if (n_got != DEPTH) begin errors++; $display("FAIL rnd%0d_count got %0d expected %0d", it, n_got, DEPTH); end
            for (int j = 0; j < DEPTH; j++) begin
                checks++;
                if (got[j] !== exp_win[j]) begin errors++; $display("FAIL rnd%0d_data[%0d] got %h expected %h", it, j, got[j], exp_win[j]); end
                checks++;
                if (got_last[j] !== (j == DEPTH - 1)) begin errors++; $display("FAIL rnd%0d_last[%0d] got %b expected %b", it, j, got_last[j], j == DEPTH - 1); end
            end
            checks++; if (stall_bad != 0) begin errors++; $display("FAIL rnd%0d_stall_stable got %0d expected 0", it, stall_bad); end
            checks++; if (rd_lag != 1) begin errors++; $display("FAIL rnd%0d_rd_valid_lag got %0d expected 1", it, rd_lag); end
            checks++; if (end_state != 0) begin errors++; $display("FAIL rnd%0d_end_state got %0d expected 0", it, end_state); end
        end
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; rd_ready = 1'b0; samp_in = 8'h00;
        test_reset();
        test_level_trigger();
        test_edge_trigger();
        test_backpressure();
        test_abort_prescaler();
        test_mask_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
